// File: rtl/dac8652_pkg.sv
// Shared definitions for the DAC8652 serializer: frame layout, command/address codes and FSM states.
// DAC_LDAC_PULSE_EN adds the LDAC_P state used for the explicit LDAC load pulse.
package dac8652_pkg;

   localparam int FRAME_W = 24;

   localparam logic [2:0] CMD_WR_BUF  = 3'b000;
   localparam logic [2:0] CMD_WR_LOAD = 3'b010;
   localparam logic [2:0] ADDR_A      = 3'b000;
   localparam logic [2:0] ADDR_B      = 3'b100;

`ifdef DAC_LDAC_PULSE_EN
   typedef enum logic [1:0] {IDLE, SHIFT, GAP, LDAC_P} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

   function automatic logic [FRAME_W-1:0] make_frame(input logic [2:0]  cmd,
                                                     input logic [2:0]  addr,
                                                     input logic [15:0] data);
      return {2'b00, cmd, addr, data};
   endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// SCLK divider: high for CLK_DIV cycles then low for CLK_DIV cycles while enabled, idles high.
// o_fall marks the last high cycle, o_rise the last low cycle (end of a bit period).
module dac_sclk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_en,
   output logic o_sclk,
   output logic o_rise,
   output logic o_fall
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          r_low;
   logic          w_half_end;

   assign w_half_end = i_en && (r_cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= '0;
         r_low <= 1'b0;
      end else if (!i_en) begin
         r_cnt <= '0;
         r_low <= 1'b0;
      end else if (w_half_end) begin
         r_cnt <= '0;
         r_low <= ~r_low;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_sclk = ~r_low;
   assign o_fall = w_half_end & ~r_low;
   assign o_rise = w_half_end & r_low;

endmodule

// File: rtl/dac8652_serializer.sv
// DAC8652 SPI serializer: start/ready request -> one (debug) or two (A, B+load) 24-bit frames.
// Define DAC_LDAC_PULSE_EN to drive an LDAC_WIDTH-cycle low pulse after the last frame.
module dac8652_serializer #(
   parameter int CLK_DIV    = 2,
   parameter int SYNC_GAP   = 4,
   parameter int LDAC_WIDTH = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [15:0] DATA_A,
   input  logic [15:0] DATA_B,
   input  logic        start,
   input  logic        DEBUG,
   input  logic [2:0]  COMMAND_IN,
   input  logic [2:0]  ADDR_IN,
   output logic        ready,
   output logic        LDAC,
   output logic        CLR,
   output logic        DIN,
   output logic        SCLK,
   output logic        SYNC
);
   import dac8652_pkg::*;

   localparam int GW = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;

   state_t               r_state;
   state_t               w_next;
   logic [FRAME_W-1:0]   r_shift;
   logic [FRAME_W-1:0]   r_frame_b;
   logic                 r_pend_b;
   logic [4:0]           r_bit;
   logic                 r_last;
   logic [GW-1:0]        r_gap;
   logic                 r_ready;
   logic                 r_sync;
   logic                 w_sclk;
   logic                 w_rise;
   logic                 w_fall;
   logic                 w_gap_done;

   dac_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
      .clk    (clk),
      .resetn (resetn),
      .i_en   (r_state == SHIFT),
      .o_sclk (w_sclk),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   assign w_gap_done = (r_gap == GW'(SYNC_GAP - 1));

`ifdef DAC_LDAC_PULSE_EN
   localparam int LW = (LDAC_WIDTH > 1) ? $clog2(LDAC_WIDTH) : 1;
   logic [LW-1:0] r_lcnt;
   logic          r_ldac;
   logic          w_ldac_done;
   assign w_ldac_done = (r_lcnt == LW'(LDAC_WIDTH - 1));
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:  if (start) w_next = SHIFT;
         SHIFT: if (w_rise && r_last) w_next = GAP;
         GAP: begin
            if (w_gap_done) begin
               if (r_pend_b) w_next = SHIFT;
`ifdef DAC_LDAC_PULSE_EN
               else          w_next = LDAC_P;
`else
               else          w_next = IDLE;
`endif
            end
         end
`ifdef DAC_LDAC_PULSE_EN
         LDAC_P: if (w_ldac_done) w_next = IDLE;
`endif
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_frame_b <= '0;
         r_pend_b  <= 1'b0;
         r_bit     <= 5'd0;
         r_last    <= 1'b0;
         r_gap     <= '0;
         r_ready   <= 1'b1;
         r_sync    <= 1'b1;
      end else begin
         r_state <= w_next;
         r_ready <= (w_next == IDLE);
         r_sync  <= (w_next != SHIFT);
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_shift   <= DEBUG ? make_frame(COMMAND_IN, ADDR_IN, DATA_A)
                                     : make_frame(CMD_WR_BUF, ADDR_A, DATA_A);
                  r_frame_b <= make_frame(CMD_WR_LOAD, ADDR_B, DATA_B);
                  r_pend_b  <= ~DEBUG;
                  r_bit     <= 5'd23;
                  r_last    <= 1'b0;
               end
            end
            SHIFT: begin
               // r_bit tracks the DAC's sample point; r_last flags that bit 0 has been sampled
               if (w_fall) begin
                  if (r_bit == 5'd0) r_last <= 1'b1;
                  else               r_bit  <= r_bit - 5'd1;
               end
               if (w_rise) r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
            end
            GAP: begin
               if (w_gap_done) begin
                  r_gap <= '0;
                  if (r_pend_b) begin
                     r_shift  <= r_frame_b;
                     r_pend_b <= 1'b0;
                     r_bit    <= 5'd23;
                     r_last   <= 1'b0;
                  end
               end else begin
                  r_gap <= r_gap + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef DAC_LDAC_PULSE_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_lcnt <= '0;
         r_ldac <= 1'b1;
      end else begin
         r_ldac <= (w_next != LDAC_P);
         if (r_state == LDAC_P && !w_ldac_done) r_lcnt <= r_lcnt + 1'b1;
         else                                   r_lcnt <= '0;
      end
   end
   assign LDAC = r_ldac;
`else
   assign LDAC = 1'b0;
`endif

   assign ready = r_ready;
   assign SYNC  = r_sync;
   assign SCLK  = w_sclk;
   assign DIN   = r_shift[FRAME_W-1];
   assign CLR   = 1'b1;

endmodule

// File: tb/tb_dac8652_serializer.sv
// Bench for dac8652_serializer: directed and random requests, frames captured off the SPI pins
// and compared against frames built from the DAC8652 frame rules.
module tb_dac8652_serializer;

   localparam int CLK_DIV    = 2;
   localparam int SYNC_GAP   = 4;
   localparam int LDAC_WIDTH = 2;
`ifdef DAC_LDAC_PULSE_EN
   localparam int       LDAC_EXTRA = LDAC_WIDTH;
   localparam logic     LDAC_IDLE  = 1'b1;
`else
   localparam int       LDAC_EXTRA = 0;
   localparam logic     LDAC_IDLE  = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic [15:0] DATA_A, DATA_B;
   logic        start, DEBUG;
   logic [2:0]  COMMAND_IN, ADDR_IN;
   logic        ready, LDAC, CLR, DIN, SCLK, SYNC;

   int tests = 0;
   int fails = 0;

   dac8652_serializer #(.CLK_DIV(CLK_DIV), .SYNC_GAP(SYNC_GAP), .LDAC_WIDTH(LDAC_WIDTH)) dut (
      .clk(clk), .resetn(resetn), .DATA_A(DATA_A), .DATA_B(DATA_B), .start(start),
      .DEBUG(DEBUG), .COMMAND_IN(COMMAND_IN), .ADDR_IN(ADDR_IN), .ready(ready),
      .LDAC(LDAC), .CLR(CLR), .DIN(DIN), .SCLK(SCLK), .SYNC(SYNC)
   );

   always #5 clk = ~clk;

   // ---------------- pin monitor (samples on the inactive edge) ----------------
   logic [23:0] exp_q[$];
   logic [23:0] got_q[$];
   int          bits_q[$];
   int          gap_q[$];
   logic [23:0] mon_word = '0;
   int          mon_bits = 0;
   int          high_run = 0;
   int          stray    = 0;
   int          ldac_act = 0;
   logic        p_sclk   = 1'b1;
   logic        p_sync   = 1'b1;

   always @(negedge clk) begin
      if (SYNC === 1'b0 && p_sync === 1'b1) begin
         mon_word = '0;
         mon_bits = 0;
         gap_q.push_back(high_run);
      end
      if (SYNC === 1'b0 && p_sclk === 1'b1 && SCLK === 1'b0) begin
         mon_word = {mon_word[22:0], DIN};
         mon_bits++;
      end
      if (SYNC === 1'b1 && p_sync === 1'b0) begin
         got_q.push_back(mon_word);
         bits_q.push_back(mon_bits);
      end
      if (SYNC === 1'b1 && p_sync === 1'b1 && SCLK !== p_sclk) stray++;
      if (LDAC !== LDAC_IDLE) ldac_act++;
      high_run = (SYNC === 1'b1) ? high_run + 1 : 0;
      p_sclk = SCLK;
      p_sync = SYNC;
   end

   // ---------------- reference and checking ----------------
   function automatic logic [23:0] ref_frame(input logic [2:0] cmd, input logic [2:0] addr,
                                             input logic [15:0] data);
      logic [23:0] f;
      f = 24'(cmd) * 24'h080000 + 24'(addr) * 24'h010000 + 24'(data);
      return f;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input int limit);
      int n;
      n = 0;
      while (ready !== 1'b1 && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic do_req(input logic dbg, input logic [2:0] cmd, input logic [2:0] addr,
                         input logic [15:0] a, input logic [15:0] b, input bit noise);
      int n, nfr, exp_lat;
      logic [23:0] e, g;
      int gb, gg;
      nfr = dbg ? 1 : 2;
      if (dbg) exp_q.push_back(ref_frame(cmd, addr, a));
      else begin
         exp_q.push_back(ref_frame(3'b000, 3'b000, a));
         exp_q.push_back(ref_frame(3'b010, 3'b100, b));
      end
      exp_lat = 1 + nfr * (48 * CLK_DIV + SYNC_GAP) + LDAC_EXTRA;
      wait_ready(2000);
      chk("ready_before_req", {31'd0, ready}, 32'd1);
      ldac_act = 0;
      DEBUG = dbg; COMMAND_IN = cmd; ADDR_IN = addr; DATA_A = a; DATA_B = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("accept_drops_ready", {31'd0, ready}, 32'd0);
      n = 1;
      while (ready !== 1'b1 && n < 2000) begin
         if (noise) begin
            start = 1'($urandom_range(0, 1));
            DEBUG = 1'($urandom_range(0, 1));
            COMMAND_IN = 3'($urandom); ADDR_IN = 3'($urandom);
            DATA_A = 16'($urandom); DATA_B = 16'($urandom);
         end
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      chk("latency", 32'(n), 32'(exp_lat));
      chk("ldac_active_cycles", 32'(ldac_act), 32'(LDAC_EXTRA));
      chk("frame_count", 32'(got_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 24'hxxxxxx;
         gb = (bits_q.size() > 0) ? bits_q.pop_front() : -1;
         gg = (gap_q.size() > 0) ? gap_q.pop_front() : -1;
         chk("frame_data", {8'd0, g}, {8'd0, e});
         chk("sclk_falls_per_frame", 32'(gb), 32'd24);
         chk("sync_gap_min", {31'd0, gg >= SYNC_GAP}, 32'd1);
      end
      got_q.delete(); bits_q.delete(); gap_q.delete();
   endtask

   initial begin
      int n;
      resetn = 1'b0; start = 1'b0; DEBUG = 1'b0; COMMAND_IN = '0; ADDR_IN = '0;
      DATA_A = '0; DATA_B = '0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_sync", {31'd0, SYNC}, 32'd1);
      chk("rst_sclk", {31'd0, SCLK}, 32'd1);
      chk("rst_clr", {31'd0, CLR}, 32'd1);
      chk("rst_din", {31'd0, DIN}, 32'd0);
      chk("rst_ldac", {31'd0, LDAC}, {31'd0, LDAC_IDLE});
      chk("rst_no_frames", 32'(got_q.size()), 32'd0);
      chk("rst_no_sclk", 32'(stray), 32'd0);

      do_req(1'b0, 3'b000, 3'b000, 16'hA5C3, 16'h1234, 1'b0);
      do_req(1'b1, 3'b011, 3'b001, 16'hFFFF, 16'h0000, 1'b0);
      do_req(1'b0, 3'b000, 3'b000, 16'h0F0F, 16'hF0F0, 1'b1);
      do_req(1'b1, 3'b101, 3'b110, 16'h8001, 16'h5555, 1'b1);
      for (int i = 0; i < 6; i++)
         do_req(1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom),
                16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

      // abort frame A around bit 10 with an asynchronous reset
      wait_ready(2000);
      DEBUG = 1'b0; DATA_A = 16'h3C3C; DATA_B = 16'hC3C3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      n = 0;
      while (mon_bits < 13 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("abort_reached_bit10", {31'd0, mon_bits >= 13}, 32'd1);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b0;
      #1;
      chk("abort_sync_high", {31'd0, SYNC}, 32'd1);
      chk("abort_sclk_high", {31'd0, SCLK}, 32'd1);
      chk("abort_ready", {31'd0, ready}, 32'd1);
      chk("abort_din", {31'd0, DIN}, 32'd0);
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      got_q.delete(); bits_q.delete(); gap_q.delete(); exp_q.delete();
      repeat (5) @(posedge clk);
      #1;
      chk("post_abort_ready", {31'd0, ready}, 32'd1);
      chk("post_abort_sync", {31'd0, SYNC}, 32'd1);
      chk("post_abort_no_frame", 32'(got_q.size()), 32'd0);
      do_req(1'b0, 3'b000, 3'b000, 16'($urandom), 16'($urandom), 1'b0);

      chk("no_sclk_while_sync_high", 32'(stray), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
